// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared op codes, FSM states and op-class helpers for alu_muldiv.
//           Optional divider selected by macro ALU_MULDIV_DIV_EN.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_XOR   = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_SLT   = 5'b00111,
    OP_SRA   = 5'b01000,
    OP_SLTU  = 5'b01001,
    OP_EQ    = 5'b01010,
    OP_PASSB = 5'b01011,
    OP_PASSA = 5'b01110,
    OP_LUI   = 5'b10100,
    OP_MULT  = 5'b10101,
    OP_MULTU = 5'b10110,
    OP_DIV   = 5'b10111,
    OP_DIVU  = 5'b11000,
    OP_MFHI  = 5'b11001,
    OP_MFLO  = 5'b11010,
    OP_MTHI  = 5'b11011,
    OP_MTLO  = 5'b11100
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_RESP = 3'd4
  } alu_state_t;

  function automatic logic op_is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Without the divider, DIV/DIVU fall through as ordinary single-cycle ops.
  function automatic logic op_is_div(input logic [4:0] op);
`ifdef ALU_MULDIV_DIV_EN
    return (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == 5'b11111) && (op != 5'b11111);
`endif
  endfunction

  function automatic logic op_is_single_cycle(input logic [4:0] op);
    return !(op_is_mul(op) || op_is_div(op));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv_if
// Brief   : Operand/result handshake bundle plus HI/LO and busy visibility.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, hi, lo, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, hi, lo, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_iter
// Brief   : WIDTH-step shift-add multiplier / restoring divider on magnitudes.
//           Divider datapath built only when ALU_MULDIV_DIV_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum;

  assign mag_a   = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b   = (is_signed && b[WIDTH-1]) ? -b : b;
  assign done    = running && (cnt == CW'(WIDTH - 1));
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});

`ifdef ALU_MULDIV_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  // acc_hi holds the partial remainder, acc_lo shifts dividend out / quotient in
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, opnd_b});
  assign rem_sub   = rem_shift[WIDTH-1:0] - opnd_b;

  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (div_mode) begin
      nxt_hi = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], rem_ge};
    end else begin
      {nxt_hi, nxt_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     div_mode <= 1'b0;
    else if (start) div_mode <= is_div;
  end
`else
  logic unused_div;
  assign unused_div       = is_div;
  assign {nxt_hi, nxt_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd_b  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= mag_a;
      opnd_b  <= mag_b;
    end else if (running) begin
      cnt     <= cnt + CW'(1);
      acc_hi  <= nxt_hi;
      acc_lo  <= nxt_lo;
      if (done) running <= 1'b0;
    end
  end

  assign hi = acc_hi;
  assign lo = acc_lo;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv
// Brief   : Registered execute-stage ALU with HI/LO and iterative MULT/DIV.
//           DIV/DIVU engine enabled by defining ALU_MULDIV_DIV_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus
);
  alu_state_t       state, state_nxt;
  logic             in_ready, accept, iter_start, iter_done;
  logic             op_mul_in, op_div_in, op_single_in;
  logic [WIDTH-1:0] iter_hi, iter_lo, alu_res, fix_hi, fix_lo;
  logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0] prod;
  logic             sign_a, sign_b, signed_op;
  logic [SHW-1:0]   shamt;

  assign op_mul_in    = op_is_mul(bus.op);
  assign op_div_in    = op_is_div(bus.op);
  assign op_single_in = op_is_single_cycle(bus.op);
  assign shamt        = bus.src_a[SHW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = (state == S_IDLE) ||
                 ((state == S_RESP) && bus.out_ready && op_single_in);
    accept     = bus.in_valid && in_ready;
    iter_start = accept && !op_single_in;
    case (state)
      S_IDLE: if (accept) state_nxt = op_mul_in ? S_MUL : (op_div_in ? S_DIV : S_RESP);
      S_MUL,
      S_DIV:  if (iter_done) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_RESP;
      S_RESP: begin
        if (accept)             state_nxt = S_RESP;
        else if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_AND:   alu_res = bus.src_a & bus.src_b;
      OP_OR:    alu_res = bus.src_a | bus.src_b;
      OP_ADD:   alu_res = bus.src_a + bus.src_b;
      OP_XOR:   alu_res = bus.src_a ^ bus.src_b;
      OP_SLL:   alu_res = bus.src_b << shamt;
      OP_SRL:   alu_res = bus.src_b >> shamt;
      OP_SUB:   alu_res = bus.src_a - bus.src_b;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SRA:   alu_res = $signed(bus.src_b) >>> shamt;
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
      OP_EQ:    alu_res = {{(WIDTH-1){1'b0}}, bus.src_a == bus.src_b};
      OP_PASSB: alu_res = bus.src_b;
      OP_PASSA: alu_res = bus.src_a;
      OP_LUI:   alu_res = bus.src_b << 16;
      OP_MFHI:  alu_res = hi_reg;
      OP_MFLO:  alu_res = lo_reg;
      default:  alu_res = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (iter_start),
    .is_signed ((bus.op == OP_MULT) || (bus.op == OP_DIV)),
    .is_div    (op_div_in),
    .a         (bus.src_a),
    .b         (bus.src_b),
    .done      (iter_done),
    .hi        (iter_hi),
    .lo        (iter_lo)
  );

`ifdef ALU_MULDIV_DIV_EN
  logic div_op, b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_op <= 1'b0;
      b_zero <= 1'b0;
    end else if (accept) begin
      div_op <= op_div_in;
      b_zero <= (bus.src_b == '0);
    end
  end
`endif

  // Engine works on magnitudes; restore signs here before HI/LO are written.
  always_comb begin
    prod = {iter_hi, iter_lo};
    if (signed_op && (sign_a ^ sign_b)) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    if (div_op) begin
      fix_lo = (signed_op && (sign_a ^ sign_b)) ? -iter_lo : iter_lo;
      fix_hi = (signed_op && sign_a) ? -iter_hi : iter_hi;
      if (b_zero) fix_lo = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      signed_op  <= 1'b0;
    end else if (accept) begin
      sign_a    <= bus.src_a[WIDTH-1];
      sign_b    <= bus.src_b[WIDTH-1];
      signed_op <= (bus.op == OP_MULT) || (bus.op == OP_DIV);
      if (op_single_in)         result_reg <= alu_res;
      if (bus.op == OP_MTHI)    hi_reg     <= bus.src_a;
      if (bus.op == OP_MTLO)    lo_reg     <= bus.src_a;
    end else if (state == S_FIX) begin
      hi_reg     <= fix_hi;
      lo_reg     <= fix_lo;
      result_reg <= fix_lo;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == S_RESP);
  assign bus.result    = result_reg;
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
  assign bus.busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_muldiv
// Brief   : Directed-vector scoreboard bench for alu_muldiv; DIV expectations
//           follow ALU_MULDIV_DIV_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    string       name;
    logic        chk_res;
    logic [31:0] res;
    logic        chk_hl;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          acc;
    int          lat;
    int          hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_muldiv_if #(.WIDTH(WIDTH)) bus ();

  alu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int busy_cnt = 0;
  int pres = 0;
  exp_t q[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every presented result is compared against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          if (pres == 0) check({q[0].name, "_latency"}, cyc - q[0].acc, q[0].lat);
          pres++;
          if (q[0].chk_res) check({q[0].name, "_result"}, bus.result, q[0].res);
          if (!bus.out_ready) begin
            check({q[0].name, "_in_ready_stall"}, {31'd0, bus.in_ready}, 32'd0);
          end else begin
            if (q[0].chk_hl) begin
              check({q[0].name, "_hi"}, bus.hi, q[0].ehi);
              check({q[0].name, "_lo"}, bus.lo, q[0].elo);
            end
            check({q[0].name, "_hold_cycles"}, pres, q[0].hold);
            void'(q.pop_front());
            pres = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic chk_res, input logic [31:0] res, input logic chk_hl,
                       input int lat, input int hold, input string name, input logic push,
                       output int acc);
    int   n;
    exp_t e;
    n = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check({name, "_accept_timeout"}, 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    acc = cyc;
    if (push) begin
      e.name = name; e.chk_res = chk_res; e.res = res; e.chk_hl = chk_hl;
      e.ehi = m_hi; e.elo = m_lo; e.acc = acc; e.lat = lat; e.hold = hold;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check({name, "_drain_timeout"}, 32'd0, 32'd1);
        q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, nb, dlat;
    logic [31:0] dres;
    bus.in_valid = 1'b0;
    bus.op = 5'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    // ADD held for 4 cycles with the consumer stalled for 3
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1, 1, 4, "add_hold", 1, a0);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain("add_hold");

    busy_cnt = 0;
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFE;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1, 32'hFFFF_FFFE, 1, 34, 1, "mult", 1, a0);
    wait_drain("mult");
    check("mult_busy_cycles", busy_cnt, 32'd33);

    m_hi = 32'h0000_0001; m_lo = 32'hFFFF_FFFE;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1, 32'hFFFF_FFFE, 1, 34, 1, "multu", 1, a0);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0000_0001, 1, 1, 1, "mfhi", 1, a0);
    issue(OP_MFLO, 32'h0, 32'h0, 1, 32'hFFFF_FFFE, 1, 1, 1, "mflo", 1, a0);
    wait_drain("mfhilo");

`ifdef ALU_MULDIV_DIV_EN
    dlat = 34;
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1, 32'hFFFF_FFFD, 1, dlat, 1, "div_neg", 1, a0);
    m_hi = 32'd2; m_lo = 32'd14;
    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd14, 1, dlat, 1, "divu", 1, a0);
    m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
    dres = 32'hFFFF_FFFF;
`else
    dlat = 1;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1, 32'h0, 1, dlat, 1, "div_neg", 1, a0);
    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'h0, 1, dlat, 1, "divu", 1, a0);
    dres = 32'h0;
`endif
    issue(OP_DIVU, 32'd5, 32'd0, 1, dres, 1, dlat, 1, "divu_by_zero", 1, a0);
    wait_drain("div");

    // Back-to-back single-cycle stream
    issue(OP_SLL,  32'd4, 32'h1,         1, 32'h0000_0010, 0, 1, 1, "sll",  1, a1);
    issue(OP_SRA,  32'd4, 32'h8000_0000, 1, 32'hF800_0000, 0, 1, 1, "sra",  1, a2);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 1, 32'h1,         0, 1, 1, "sltu", 1, a3);
    check("stream_accept_gap1", a2 - a1, 32'd1);
    check("stream_accept_gap2", a3 - a2, 32'd1);
    issue(OP_SUB, 32'h0, 32'h1, 1, 32'hFFFF_FFFF, 0, 1, 1, "sub_wrap", 1, a0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 0, 1, 1, "slt_signed", 1, a0);
    issue(OP_EQ, 32'h5, 32'h5, 1, 32'h1, 0, 1, 1, "eq", 1, a0);
    issue(OP_LUI, 32'h0, 32'h0000_1234, 1, 32'h1234_0000, 0, 1, 1, "lui", 1, a0);
    issue(5'b01100, 32'h1, 32'h2, 1, 32'h0, 1, 1, 1, "undef_op", 1, a0);
    m_hi = 32'h0000_A5A5;
    issue(OP_MTHI, 32'h0000_A5A5, 32'h0, 0, 32'h0, 1, 1, 1, "mthi", 1, a0);
    m_lo = 32'h0000_5A5A;
    issue(OP_MTLO, 32'h0000_5A5A, 32'h0, 0, 32'h0, 1, 1, 1, "mtlo", 1, a0);
    issue(OP_MFHI, 32'h0, 32'h0, 1, 32'h0000_A5A5, 1, 1, 1, "mfhi_after_mthi", 1, a0);
    wait_drain("stream");

    // Reset in the middle of a MULT: the result must never appear
    issue(OP_MULT, 32'd3, 32'd4, 0, 32'h0, 0, 34, 1, "mult_abort", 0, a0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    nb = n_out;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (40) @(posedge clk);
    check("abort_no_out_valid", n_out - nb, 32'd0);
    #1;
    issue(OP_ADD, 32'd2, 32'd2, 1, 32'd4, 1, 1, 1, "add_after_reset", 1, a0);
    wait_drain("add_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered execute-stage ALU for the MIPS core. It extends the combinational ALU operation set with an iterative multiply/divide engine and architectural HI/LO registers. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls naturally during multi-cycle MULT/DIV operations. It sits between decode/register-read and the writeback mux.

## Interface
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): number of shift-amount bits taken from `src_a`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted on a cycle with `in_valid && in_ready`.
- `op` in 5: operation code (see Operation).
- `src_a` in WIDTH: operand A; its low `SHW` bits are the shift amount.
- `src_b` in WIDTH: operand B.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer takes the result.
- `result` out WIDTH: operation result.
- `hi` out WIDTH: HI register, continuously visible.
- `lo` out WIDTH: LO register, continuously visible.
- `busy` out 1: high while a multiply or divide is iterating.

## Operation
- Single-cycle ops, with codes:
  - AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110
  - SLT 00111 (signed), SRA 01000, SLTU 01001, EQ 01010, PASSB 01011, PASSA 01110, LUI 10100 (`src_b << 16`)
- HI/LO ops:
  - MTHI 11011 writes `hi = src_a`; MTLO 11100 writes `lo = src_a`.
  - MFHI 11001 returns `hi`; MFLO 11010 returns `lo`.
- Multi-cycle ops: MULT 10101, MULTU 10110, DIV 10111, DIVU 11000.
  - Each writes `{hi,lo}`; `result` returns the new `lo`.
- Undefined op codes: accepted, return `result = 0`, leave HI/LO unchanged.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH; no overflow trap.
  - Compare ops return 0 or 1, zero-extended.
- Signed MULT/DIV: the engine iterates on magnitudes, then a fix-up step negates as required.
  - Product sign = sign(a) XOR sign(b).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Division by zero: `hi = src_a`, `lo` = all ones, same latency as a normal divide.
- State machine:
  - IDLE → RESP for a single-cycle op.
  - IDLE → MUL or DIV for a multi-cycle op.
  - MUL/DIV run WIDTH iterations → FIX (one cycle: sign fix-up and HI/LO write) → RESP.
  - RESP → IDLE on `out_ready`.
  - MUL is shift-add; DIV is restoring, one quotient bit per cycle.
- Operands are captured at acceptance; `src_a`/`src_b` may change freely afterwards.
- A MFHI/MFLO issued after a MULT/DIV is only accepted once that MULT/DIV has drained, so it always sees the new value.

## Timing
- Reset values: `in_ready = 1`, `out_valid = 0`, `result = 0`, `hi = 0`, `lo = 0`, `busy = 0`, state = IDLE.
- `in_ready = (state == IDLE) || (state == RESP && out_ready && op_is_single_cycle)`.
  - This gives back-to-back single-cycle throughput of 1 op/cycle.
- Single-cycle op latency: `out_valid` rises on the cycle after acceptance.
- MULT/DIV latency: `out_valid` rises WIDTH+2 cycles after acceptance (34 for WIDTH=32).
  - `busy` is high for the WIDTH+1 cycles in MUL/DIV and FIX.
- `result` and `out_valid` are held stable while `out_valid && !out_ready`.
- HI/LO write timing:
  - MTHI/MTLO update HI/LO on the acceptance edge.
  - MULT/DIV update HI/LO on the FIX→RESP edge.
- Reset asserted mid-iteration:
  - Aborts immediately; HI/LO clear to 0.
  - No result is emitted after reset releases.

## Configuration
- `ALU_MULDIV_DIV_EN`
  - Defined: the DIV/DIVU engine is built as described above.
  - Undefined: no divider logic is built. DIV/DIVU complete as single-cycle ops, return `result = 0`, and leave HI/LO unchanged. MULT/MULTU are unaffected.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_op_t` enum with all codes above;
  - the `alu_state_t` enum (IDLE, MUL, DIV, FIX, RESP);
  - the helper `op_is_single_cycle()`.
- Sub-module `muldiv_iter` holds the shift-add/restoring iteration datapath and its counter.
  - Interface: start, signed flag, div flag, operands in; done, hi/lo out.
  - The top level owns the handshake, HI/LO registers and single-cycle ops.

## Test plan
- ADD `0x7FFFFFFF + 1`, `out_ready` held low for 3 cycles → `result = 0x80000000` held stable 4 cycles, `in_ready` low until drained.
- MULT `0xFFFFFFFF × 0x00000002` → after 34 cycles `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFFE`; MULTU with the same operands → `hi = 0x00000001`, `lo = 0xFFFFFFFE`.
- DIV `0xFFFFFFF9 (−7) / 2` → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`; DIVU `100 / 7` → `lo = 14`, `hi = 2`.
- DIVU `5 / 0` → `hi = 5`, `lo = 0xFFFFFFFF`, latency 34; with `ALU_MULDIV_DIV_EN` undefined → `result = 0` after 1 cycle, HI/LO unchanged.
- Back-to-back stream SLL (`a = 4`, `b = 1`), SRA (`a = 4`, `b = 0x80000000`), SLTU (`1`, `0xFFFFFFFF`) with `out_ready = 1` → results `0x10`, `0xF8000000`, `1` on consecutive cycles.
- `rst_n` pulsed low 10 cycles into a MULT → no `out_valid` after release, `hi = lo = 0`, next ADD `2 + 2` returns 4.
